// File: rtl/rx_timer_pkg.sv
// Shared state encoding and byte-size constants for the I2C receive bit timer.
package rx_timer_pkg;

    localparam int BITS_PER_BYTE = 8;
    localparam int CNT_W         = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNT     = 3'd1,
        WAIT_FALL = 3'd2,
        ACK_DRIVE = 3'd3,
        ACK_HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/rx_timer_flex_counter.sv
// Up-counter with synchronous clear that stops at rollover_val instead of wrapping,
// so the bit count of a byte can never run past a full byte.
module rx_timer_flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable && (count_q != rollover_val)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/rx_timer.sv
// I2C receive bit timer: counts sampled bits, flags the full byte and sequences the ACK slot.
// Optional macro RX_TIMER_NACK_EN adds nack_req/nack to NACK a byte instead of ACKing it.
module rx_timer
    import rx_timer_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             rising_edge,
    input  logic             falling_edge,
    input  logic             start,
    input  logic             stop,
`ifdef RX_TIMER_NACK_EN
    input  logic             nack_req,
    output logic             nack,
`endif
    output logic             shift_strobe,
    output logic             byte_received,
    output logic             ack_prep,
    output logic             ack_done,
    output logic [CNT_W-1:0] bit_count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] FULL_BYTE = CNT_W'(BITS_PER_BYTE);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BITS_PER_BYTE - 1);

    state_t state_q, state_d;
    logic   cnt_clear, cnt_en;
    logic   shift_strobe_d, byte_pend_d, byte_pend_q, byte_received_d;
    logic   ack_prep_d, ack_done_d;
`ifdef RX_TIMER_NACK_EN
    logic   nack_q, nack_d;
`endif

    rx_timer_flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_flex_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .rollover_val (FULL_BYTE),
        .count_out    (bit_count)
    );

    always_comb begin
        state_d        = state_q;
        cnt_clear      = 1'b0;
        cnt_en         = 1'b0;
        shift_strobe_d = 1'b0;
        byte_pend_d    = 1'b0;
        ack_done_d     = 1'b0;
`ifdef RX_TIMER_NACK_EN
        nack_d         = nack_q;
`endif
        // Bus conditions override everything, and swallow any edge in the same cycle.
        if (stop) begin
            state_d   = IDLE;
            cnt_clear = 1'b1;
        end else if (start) begin
            state_d   = COUNT;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                COUNT: begin
                    if (rising_edge) begin
                        shift_strobe_d = 1'b1;
                        cnt_en         = 1'b1;
                        if (bit_count == LAST_BIT) begin
                            state_d     = WAIT_FALL;
                            byte_pend_d = 1'b1;
                        end
                    end
                end
                WAIT_FALL: begin
                    if (falling_edge) begin
                        state_d = ACK_DRIVE;
`ifdef RX_TIMER_NACK_EN
                        nack_d  = nack_req;
`endif
                    end
                end
                ACK_DRIVE: begin
                    if (rising_edge) begin
                        state_d = ACK_HOLD;
                    end
                end
                ACK_HOLD: begin
                    if (falling_edge) begin
                        state_d    = COUNT;
                        cnt_clear  = 1'b1;
                        ack_done_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // byte_received trails the final strobe by one cycle, unless the byte was aborted.
        byte_received_d = byte_pend_q && !(start || stop);
`ifdef RX_TIMER_NACK_EN
        ack_prep_d = ((state_d == ACK_DRIVE) || (state_d == ACK_HOLD)) && !nack_d;
`else
        ack_prep_d = (state_d == ACK_DRIVE) || (state_d == ACK_HOLD);
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_strobe  <= 1'b0;
            byte_pend_q   <= 1'b0;
            byte_received <= 1'b0;
            ack_prep      <= 1'b0;
            ack_done      <= 1'b0;
            busy          <= 1'b0;
`ifdef RX_TIMER_NACK_EN
            nack_q        <= 1'b0;
            nack          <= 1'b0;
`endif
        end else begin
            shift_strobe  <= shift_strobe_d;
            byte_pend_q   <= byte_pend_d;
            byte_received <= byte_received_d;
            ack_prep      <= ack_prep_d;
            ack_done      <= ack_done_d;
            busy          <= (state_d != IDLE);
`ifdef RX_TIMER_NACK_EN
            nack_q        <= nack_d;
            nack          <= ack_done_d && nack_q;
`endif
        end
    end

endmodule

// File: tb/tb_rx_timer.sv
// Self-checking bench for rx_timer: a cycle-by-cycle vector table for a full byte + ACK,
// then directed sequences for abort, repeated START, async reset and (optionally) NACK.
module tb_rx_timer;

    logic       clk;
    logic       n_rst;
    logic       rising_edge, falling_edge, start, stop;
    logic       shift_strobe, byte_received, ack_prep, ack_done, busy;
    logic [3:0] bit_count;
`ifdef RX_TIMER_NACK_EN
    logic       nack_req, nack;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       r, f, s, p;
        logic [8:0] exp;   // {strobe, byte, ack_prep, ack_done, busy, bit_count}
    } vec_t;

    vec_t tbl[$];

    rx_timer dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rising_edge   (rising_edge),
        .falling_edge  (falling_edge),
        .start         (start),
        .stop          (stop),
`ifdef RX_TIMER_NACK_EN
        .nack_req      (nack_req),
        .nack          (nack),
`endif
        .shift_strobe  (shift_strobe),
        .byte_received (byte_received),
        .ack_prep      (ack_prep),
        .ack_done      (ack_done),
        .bit_count     (bit_count),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic f, input logic s, input logic p);
        rising_edge  = r;
        falling_edge = f;
        start        = s;
        stop         = p;
        tick();
        rising_edge  = 1'b0;
        falling_edge = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
    endtask

    function automatic void add(input logic r, input logic f, input logic s, input logic p,
                                input logic st, input logic by, input logic ap,
                                input logic ad, input logic bz, input int cnt);
        vec_t v;
        v.r   = r;
        v.f   = f;
        v.s   = s;
        v.p   = p;
        v.exp = {st, by, ap, ad, bz, 4'(cnt)};
        tbl.push_back(v);
    endfunction

    function automatic logic [15:0] outs();
        return {7'b0, shift_strobe, byte_received, ack_prep, ack_done, busy, bit_count};
    endfunction

    task automatic byte_to_ack();
        drive(0, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 0, 0);
            drive(0, 1, 0, 0);
        end
    endtask

    initial begin
        int bytes_seen;
        int strobes_seen;

        // start, one ignored fall, bits 1..7, then bit 8 and the full ACK slot
        add(0,0,1,0, 0,0,0,0,1,0);
        add(0,1,0,0, 0,0,0,0,1,0);
        for (int k = 1; k <= 7; k++) begin
            add(1,0,0,0, 1,0,0,0,1,k);
            add(0,0,0,0, 0,0,0,0,1,k);
            add(0,1,0,0, 0,0,0,0,1,k);
        end
        add(1,0,0,0, 1,0,0,0,1,8);
        add(0,0,0,0, 0,1,0,0,1,8);
        add(0,1,0,0, 0,0,1,0,1,8);
        add(0,0,0,0, 0,0,1,0,1,8);
        add(1,0,0,0, 0,0,1,0,1,8);
        add(0,0,0,0, 0,0,1,0,1,8);
        add(0,1,0,0, 0,0,0,1,1,0);
        add(0,0,0,0, 0,0,0,0,1,0);
        add(0,0,0,1, 0,0,0,0,0,0);

        rising_edge  = 1'b0;
        falling_edge = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
`ifdef RX_TIMER_NACK_EN
        nack_req     = 1'b0;
`endif
        n_rst = 1'b0;
        #12;
        check("reset_outputs", outs(), 16'h0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // edges before any START are ignored
        drive(1, 0, 0, 0);
        check("idle_rise_ignored", outs(), 16'h0);
        drive(0, 1, 0, 0);
        check("idle_fall_ignored", outs(), 16'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].p);
            check($sformatf("row%0d", i), outs(), {7'b0, tbl[i].exp});
        end

        // STOP mid-byte aborts; later edges produce nothing
        drive(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0);
            drive(0, 1, 0, 0);
        end
        check("mid_byte_count4", 16'(bit_count), 16'd4);
        drive(0, 0, 0, 1);
        check("stop_idle", outs(), 16'h0);
        strobes_seen = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0);
            strobes_seen += int'(shift_strobe);
            drive(0, 1, 0, 0);
            strobes_seen += int'(shift_strobe);
        end
        check("post_stop_no_strobe", 16'(strobes_seen), 16'd0);
        check("post_stop_count", 16'(bit_count), 16'd0);

        // repeated START after 5 bits, then a back-to-back byte (fall right after 8th rise)
        drive(0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0);
            drive(0, 1, 0, 0);
        end
        check("five_bits", 16'(bit_count), 16'd5);
        drive(0, 0, 1, 0);
        check("rstart_clears", {14'b0, busy, shift_strobe}, 16'b10);
        check("rstart_count0", 16'(bit_count), 16'd0);
        bytes_seen   = 0;
        strobes_seen = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 0, 0);
            bytes_seen   += int'(byte_received);
            strobes_seen += int'(shift_strobe);
            drive(0, 1, 0, 0);
            bytes_seen   += int'(byte_received);
        end
        check("fast_fall_ack_prep", 16'(ack_prep), 16'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            bytes_seen += int'(byte_received);
        end
        check("rstart_byte_once", 16'(bytes_seen), 16'd1);
        check("rstart_strobes8", 16'(strobes_seen), 16'd8);
        check("rstart_count8", 16'(bit_count), 16'd8);
        drive(0, 0, 0, 1);
        check("stop_in_ack", outs(), 16'h0);

        // START and STOP together with a rise: STOP wins, no strobe
        drive(1, 0, 1, 1);
        check("start_stop_same", outs(), 16'h0);
        tick();
        check("start_stop_after", outs(), 16'h0);

        // START coincident with a rise inside COUNT suppresses the strobe
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        check("count_one", 16'(bit_count), 16'd1);
        drive(1, 0, 1, 0);
        check("start_with_rise", {11'b0, shift_strobe, bit_count}, 16'h0);
        drive(0, 0, 0, 1);

        // asynchronous reset inside the ACK slot drops ack_prep before any clock edge
        byte_to_ack();
        check("ack_drive_prep", 16'(ack_prep), 16'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_reset_outs", outs(), 16'h0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        drive(1, 0, 0, 0);
        check("post_reset_ignored", outs(), 16'h0);

`ifdef RX_TIMER_NACK_EN
        drive(0, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 0, 0);
            if (k == 7) nack_req = 1'b1;
            drive(0, 1, 0, 0);
            nack_req = 1'b0;
        end
        check("nack_no_prep", {14'b0, busy, ack_prep}, 16'b10);
        drive(1, 0, 0, 0);
        check("nack_hold_no_prep", 16'(ack_prep), 16'd0);
        drive(0, 1, 0, 0);
        check("nack_pulse", {13'b0, nack, ack_done, ack_prep}, 16'b110);
        tick();
        check("nack_single", {14'b0, nack, ack_done}, 16'b00);
        drive(0, 0, 0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
